// File: rtl/fetch_unit.sv
// fetch_fifo: power-of-two circular queue with synchronous flush (prefetch buffer, PC tag queue).
// Latency: a pushed entry reaches head_dat on the cycle after the push; head_dat is read combinationally.
// Backpressure: none inside; the caller only pushes when there is space (push while full needs a pop).
// Ports: clk/reset, flush (drop all entries), push/push_dat, pop, head_dat (oldest entry), count.
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  output logic [W-1:0]           head_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Storage is not reset; consumers qualify head_dat with count.
  // A push while full lands in the slot being popped, which is read before the edge.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
  assign count    = cnt_q;
endmodule

// fetch_unit: sequential instruction prefetcher with redirect flush and in-order response tagging.
// Latency: request issues the first edge after reset release; a response reaches decode one cycle later.
// Backpressure: requests throttle when buffered + in-flight reaches FIFO_DEPTH; decode stalls hold the head.
// Ports: clk, reset (async active-low); imem_req_* (valid/ready/addr); imem_rsp_* (valid/data, never stalled);
//        if_* (valid/ready/instr/pc) towards decode; redirect_valid/redirect_pc (taken branch target).
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  typedef enum logic {RUN, DRAIN} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ibuf_ent_t;

  state_t        state_q, state_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [31:0]   fetch_pc;
  logic          active_q;

  logic [CW-1:0] buf_cnt;
  logic [CW-1:0] tag_cnt;
  logic [31:0]   tag_pc;
  ibuf_ent_t     buf_head;
  ibuf_ent_t     buf_wr;
  logic [CW:0]   inflight;

  logic req_fire;
  logic rsp_fire;
  logic rsp_live;
  logic buf_pop;

  assign req_fire = imem_req_valid && imem_req_ready;
  // With nothing outstanding a response can only be a leftover from before reset.
  assign rsp_fire = imem_rsp_valid && (outst_q != '0);
  // In DRAIN every response belongs to a pre-redirect fetch; the tag check guards the
  // same condition from the queue side.
  assign rsp_live = rsp_fire && (state_q == RUN) && (tag_cnt != '0) && !redirect_valid;
  assign buf_pop  = if_valid && if_ready && !redirect_valid;
  assign outst_d  = outst_q + CW'(req_fire) - CW'(rsp_fire);
  assign inflight = {1'b0, buf_cnt} + {1'b0, outst_q};

  // active_q delays the first request to the first edge after reset release.
  assign imem_req_valid = active_q && !redirect_valid && (inflight < DEPTH_W);
  assign imem_req_addr  = fetch_pc;

  assign buf_wr   = '{pc: tag_pc, instr: imem_rsp_data};
  assign if_valid = (buf_cnt != '0);
  assign if_instr = if_valid ? buf_head.instr : '0;
  assign if_pc    = if_valid ? buf_head.pc    : '0;

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    if (redirect_valid) begin
      // Everything still in flight after this cycle is from the old path.
      drop_d  = outst_d;
      state_d = (outst_d != '0) ? DRAIN : RUN;
    end else if (state_q == DRAIN && rsp_fire) begin
      drop_d = drop_q - CW'(1);
      if (drop_q == CW'(1)) state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      drop_q   <= '0;
      outst_q  <= '0;
      fetch_pc <= RESET_PC;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      drop_q   <= drop_d;
      outst_q  <= outst_d;
      active_q <= 1'b1;
      if (redirect_valid) fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      else if (req_fire)  fetch_pc <= fetch_pc + 32'd4;
    end
  end

  fetch_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_tag_q (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .push     (req_fire),
    .push_dat (fetch_pc),
    .pop      (rsp_live),
    .head_dat (tag_pc),
    .count    (tag_cnt)
  );

  fetch_fifo #(.W($bits(ibuf_ent_t)), .DEPTH(FIFO_DEPTH)) u_ibuf (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .push     (rsp_live),
    .push_dat (buf_wr),
    .pop      (buf_pop),
    .head_dat (buf_head),
    .count    (buf_cnt)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven, hand-sequenced and randomized checks of fetch_unit against an in-order memory model.
// Latency: n/a (testbench).
// Backpressure: the bench drives random imem_req_ready / if_ready stalls.
module tb_fetch_unit;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] RPC2  = 32'hFFFF_FFF8;
  localparam logic [31:0] STALE = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid, if_ready = 1'b0;
  logic [31:0] if_instr, if_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic        u2_req_valid;
  logic [31:0] u2_req_addr;
  logic        u2_if_valid;
  logic [31:0] u2_if_instr, u2_if_pc;
  logic        one = 1'b1;
  logic        zero = 1'b0;
  logic [31:0] zero32 = '0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  fetch_unit #(.RESET_PC(RPC2), .FIFO_DEPTH(DEPTH)) dut2 (
    .clk(clk), .reset(reset),
    .imem_req_valid(u2_req_valid), .imem_req_ready(one), .imem_req_addr(u2_req_addr),
    .imem_rsp_valid(zero), .imem_rsp_data(zero32),
    .if_valid(u2_if_valid), .if_ready(zero), .if_instr(u2_if_instr), .if_pc(u2_if_pc),
    .redirect_valid(zero), .redirect_pc(zero32)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        ifr;
    logic        e_rv;
    logic [31:0] e_ra;
    logic        e_iv;
    logic [31:0] e_pc;
  } vec_t;

  mreq_t       mq[$];
  logic [31:0] q2[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;

  logic        s_req_vld, s_acc, s_if_vld;
  logic [31:0] s_req_addr, s_if_pc, s_if_instr;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, play the memory, sample outputs.
  task automatic drive_cycle(input logic rdy, input logic ifr, input logic redir,
                             input logic [31:0] rpc, input int lat, input logic hold, input logic inj);
    @(negedge clk);
    imem_req_ready = rdy;
    if_ready       = ifr;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (inj) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = STALE;
    end else if (!hold && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mq[0].addr);
      mq.delete(0);
    end
    #1;
    s_req_vld  = imem_req_valid;
    s_req_addr = imem_req_addr;
    s_acc      = imem_req_valid && rdy;
    s_if_vld   = if_valid;
    s_if_pc    = if_pc;
    s_if_instr = if_instr;
    if (s_acc) mq.push_back('{addr: imem_req_addr, due: cyc + lat});
    if (u2_req_valid) q2.push_back(u2_req_addr);
    cyc++;
  endtask

  task automatic do_reset(input logic inj);
    @(negedge clk);
    reset = 1'b0;
    imem_req_ready = 1'b0;
    if_ready = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = inj;
    imem_rsp_data = STALE;
    mq.delete();
    q2.delete();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_req_vld", imem_req_valid, 0);
      chk("rst_if_vld", if_valid, 0);
      chk("rst_if_pc", if_pc, 0);
      chk("rst_if_instr", if_instr, 0);
      chk("rst_req_addr", imem_req_addr, RPC);
      chk("rst_req_addr2", u2_req_addr, RPC2);
      @(negedge clk);
    end
    reset = 1'b1;
    imem_rsp_valid = 1'b0;
    #1;
    chk("rel_req_vld_before_edge", imem_req_valid, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[14];
    logic [31:0] exp_pc, exp_addr, prev_addr, rpc;
    logic        prev_vld, prev_acc, prev_redir, post_redir, redir, rdy, ifr, hold, found;
    int          n_cons, lat;

    // rst rdy ifr | req_vld req_addr | if_vld if_pc
    tbl[0]  = '{1, 1, 1, 1, 32'h00, 0, 32'h0};
    tbl[1]  = '{0, 1, 1, 1, 32'h04, 0, 32'h0};
    tbl[2]  = '{0, 1, 1, 1, 32'h08, 1, 32'h0};
    tbl[3]  = '{0, 1, 1, 1, 32'h0C, 1, 32'h4};
    tbl[4]  = '{0, 1, 1, 1, 32'h10, 1, 32'h8};
    tbl[5]  = '{1, 1, 0, 1, 32'h00, 0, 32'h0};
    tbl[6]  = '{0, 1, 0, 1, 32'h04, 0, 32'h0};
    tbl[7]  = '{0, 1, 0, 1, 32'h08, 1, 32'h0};
    tbl[8]  = '{0, 1, 0, 1, 32'h0C, 1, 32'h0};
    tbl[9]  = '{0, 1, 0, 0, 32'h00, 1, 32'h0};
    tbl[10] = '{0, 1, 0, 0, 32'h00, 1, 32'h0};
    tbl[11] = '{0, 1, 1, 0, 32'h00, 1, 32'h0};
    tbl[12] = '{0, 1, 1, 1, 32'h10, 1, 32'h4};
    tbl[13] = '{0, 1, 1, 1, 32'h14, 1, 32'h8};

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].rst) do_reset(1'b0);
      drive_cycle(tbl[i].rdy, tbl[i].ifr, 1'b0, 32'h0, 1, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_req_vld", i), s_req_vld, tbl[i].e_rv);
      if (tbl[i].e_rv) chk($sformatf("tbl%0d_req_addr", i), s_req_addr, tbl[i].e_ra);
      chk($sformatf("tbl%0d_if_vld", i), s_if_vld, tbl[i].e_iv);
      if (tbl[i].e_iv) begin
        chk($sformatf("tbl%0d_if_pc", i), s_if_pc, tbl[i].e_pc);
        chk($sformatf("tbl%0d_if_instr", i), s_if_instr, instr_of(tbl[i].e_pc));
      end
    end

    // Second instance: reset PC near the top of the address space wraps to 0.
    chk("wrap_req_count", q2.size() >= 3, 1);
    if (q2.size() >= 3) begin
      chk("wrap_addr0", q2[0], 32'hFFFF_FFF8);
      chk("wrap_addr1", q2[1], 32'hFFFF_FFFC);
      chk("wrap_addr2", q2[2], 32'h0000_0000);
    end
    chk("wrap_if_vld", u2_if_valid, 0);
    chk("wrap_if_pc", u2_if_pc, 0);
    chk("wrap_if_instr", u2_if_instr, 0);

    // Redirect with three requests in flight on a 4-cycle memory.
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) drive_cycle(1, 1, 0, 32'h0, 4, 0, 0);
    chk("r34_outstanding", mq.size(), 3);
    drive_cycle(1, 1, 1, 32'h100, 4, 0, 0);
    chk("r34_req_vld_in_redir", s_req_vld, 0);
    drive_cycle(1, 1, 0, 32'h0, 4, 0, 0);
    chk("r34_next_vld", s_req_vld, 1);
    chk("r34_next_addr", s_req_addr, 32'h100);
    chk("r34_if_low", s_if_vld, 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      drive_cycle(1, 1, 0, 32'h0, 4, 0, 0);
      if (s_if_vld) begin
        found = 1;
        chk("r34_first_pc", s_if_pc, 32'h100);
        chk("r34_first_instr", s_if_instr, instr_of(32'h100));
      end
    end
    chk("r34_if_timeout", found, 1);

    // Unaligned target, with decode ready during the redirect cycle.
    drive_cycle(1, 1, 1, 32'h203, 4, 0, 0);
    drive_cycle(1, 1, 0, 32'h0, 4, 0, 0);
    chk("r35_if_low", s_if_vld, 0);
    chk("r35_req_vld", s_req_vld, 1);
    chk("r35_req_addr", s_req_addr, 32'h200);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      drive_cycle(1, 1, 0, 32'h0, 4, 0, 0);
      if (s_if_vld) begin
        found = 1;
        chk("r35_first_pc", s_if_pc, 32'h200);
        chk("r35_first_instr", s_if_instr, instr_of(32'h200));
      end
    end
    chk("r35_if_timeout", found, 1);

    // Reset with two requests outstanding; stale responses during and after reset.
    do_reset(1'b0);
    for (int i = 0; i < 2; i++) drive_cycle(1, 0, 0, 32'h0, 4, 0, 0);
    chk("r37_outstanding", mq.size(), 2);
    do_reset(1'b1);
    drive_cycle(1, 1, 0, 32'h0, 2, 0, 1);
    chk("r37_first_req_vld", s_acc, 1);
    chk("r37_first_req_addr", s_req_addr, RPC);
    chk("r37_if_low", s_if_vld, 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      drive_cycle(1, 1, 0, 32'h0, 2, 0, 0);
      if (s_if_vld) begin
        found = 1;
        chk("r37_first_pc", s_if_pc, RPC);
        chk("r37_first_instr", s_if_instr, instr_of(RPC));
      end
    end
    chk("r37_if_timeout", found, 1);

    // Random traffic: decode must see a sequential stream starting at the latest target.
    do_reset(1'b0);
    exp_pc = RPC;
    exp_addr = RPC;
    prev_vld = 0; prev_acc = 0; prev_redir = 0; prev_addr = '0; post_redir = 0;
    n_cons = 0;
    for (int k = 0; k < 3000; k++) begin
      redir = ($urandom_range(0, 15) == 0);
      rpc   = $urandom;
      rdy   = ($urandom_range(0, 3) != 0);
      ifr   = ($urandom_range(0, 3) != 0);
      lat   = $urandom_range(1, 5);
      hold  = ($urandom_range(0, 4) == 0);
      drive_cycle(rdy, ifr, redir, rpc, lat, hold, 1'b0);
      if (post_redir) chk("rand_if_low_after_redir", s_if_vld, 0);
      if (prev_vld && !prev_acc && !prev_redir && !redir) begin
        chk("rand_req_vld_stable", s_req_vld, 1);
        chk("rand_req_addr_stable", s_req_addr, prev_addr);
      end
      if (redir) begin
        chk("rand_req_vld_in_redir", s_req_vld, 0);
        exp_pc   = rpc & 32'hFFFF_FFFC;
        exp_addr = rpc & 32'hFFFF_FFFC;
      end else begin
        if (s_acc) begin
          chk("rand_req_addr", s_req_addr, exp_addr);
          exp_addr = exp_addr + 32'd4;
        end
        if (s_if_vld && ifr) begin
          chk("rand_if_pc", s_if_pc, exp_pc);
          chk("rand_if_instr", s_if_instr, instr_of(exp_pc));
          exp_pc = exp_pc + 32'd4;
          n_cons++;
        end
      end
      chk("rand_outstanding_bound", mq.size() <= DEPTH, 1);
      prev_vld   = s_req_vld;
      prev_acc   = s_acc;
      prev_addr  = s_req_addr;
      prev_redir = redir;
      post_redir = redir;
    end
    chk("rand_liveness", n_cons >= 300, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: prefetch buffer entries, power of two, range 2..16.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request to instruction memory.
REQ-006 SHALL have port imem_req_ready  input  1  memory accepts the request this cycle.
REQ-007 SHALL have port imem_req_addr  output  32  word-aligned fetch address.
REQ-008 SHALL have port imem_rsp_valid  input  1  instruction word returned; responses are in order, at least 1 cycle after acceptance, never back-pressured.
REQ-009 SHALL have port imem_rsp_data  input  32  returned instruction word.
REQ-010 SHALL have port if_valid  output  1  instruction available to decode.
REQ-011 SHALL have port if_ready  input  1  decode consumes the instruction this cycle.
REQ-012 SHALL have port if_instr  output  32  instruction at buffer head.
REQ-013 SHALL have port if_pc  output  32  address of if_instr.
REQ-014 SHALL have port redirect_valid  input  1  branch/jump taken; discard all younger fetches.
REQ-015 SHALL have port redirect_pc  input  32  new fetch target.

Function
REQ-016 Request accepted when imem_req_valid and imem_req_ready are both high; response consumed when imem_rsp_valid is high; instruction consumed when if_valid and if_ready are both high.
REQ-017 fetch_pc register SHALL drive imem_req_addr; +4 on each accepted request, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-018 imem_req_valid SHALL be high only when (buffer occupancy + outstanding requests) < FIFO_DEPTH and redirect_valid is low.
REQ-019 imem_req_valid and imem_req_addr SHALL remain stable until accepted unless redirect_valid is asserted.
REQ-020 Outstanding counter: +1 per accepted request, -1 per response, both in one cycle = no change; never exceeds FIFO_DEPTH.
REQ-021 Each request SHALL carry its address into a FIFO_DEPTH-entry PC tag queue; responses pair with the oldest tag.
REQ-022 Non-discarded response SHALL be written to the prefetch buffer with its PC the same cycle; visible on if_valid the next cycle (1-cycle response-to-decode latency).
REQ-023 Buffer: full = FIFO_DEPTH entries; simultaneous write and consume when full or empty SHALL both succeed; if_instr/if_pc SHALL hold while if_valid high and if_ready low.
REQ-024 State machine RUN/DRAIN: RUN = normal; redirect_valid moves to DRAIN with drop_count = outstanding requests after this cycle's accept/response, or stays RUN if that count is 0.
REQ-025 DRAIN: each response decrements drop_count and is discarded (not buffered); drop_count reaching 0 returns to RUN; new requests MAY issue in DRAIN.
REQ-026 On redirect_valid: buffer and tag queue SHALL empty; if_valid low next cycle; fetch_pc = {redirect_pc[31:2],2'b00} next cycle; a response or acceptance in the redirect cycle is counted as discarded.
REQ-027 Redirect during DRAIN SHALL recompute drop_count per REQ-024 and restart from the new target.
REQ-028 if_ready in the redirect cycle SHALL NOT cause a second consume of the flushed head.

Reset
REQ-029 During reset low: imem_req_valid=0, if_valid=0, if_instr=0, if_pc=0, fetch_pc=RESET_PC, state RUN, buffer empty, outstanding and drop_count 0.
REQ-030 Reset asserted mid-operation SHALL abandon outstanding requests; responses arriving while reset is low SHALL be ignored.
REQ-031 First request SHALL assert the first rising edge after reset deasserts, address RESET_PC.

Verification
REQ-032 Reset release, imem_req_ready=1, 1-cycle response, if_ready=1 -> requests 0x0,0x4,0x8...; if_valid first high 2 cycles after first request; one instruction per cycle.
REQ-033 if_ready=0 with immediate memory -> exactly FIFO_DEPTH requests (0x0..0xC default), then imem_req_valid=0; if_ready=1 -> order 0x0,0x4 preserved.
REQ-034 3 requests outstanding (3-cycle latency), redirect_pc=0x100 -> next request 0x100; 3 stale responses dropped; first if_pc=0x100.
REQ-035 redirect_pc=0x103 -> fetch address 0x100.
REQ-036 RESET_PC=32'hFFFF_FFF8 -> addresses 0xFFFF_FFF8,0xFFFF_FFFC,0x0.
REQ-037 reset low with 2 outstanding, responses arriving during and after reset -> no if_valid until a post-reset fetch returns; first if_pc=RESET_PC.
